// File: rtl/peak_frame_sequencer_if.sv
// rtl/peak_frame_sequencer_if.sv - frame link between the sequencer and the peak_abs detector
interface peak_frame_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int IW    = 4
);
  logic             start;
  logic             in_valid;
  logic [WIDTH-1:0] sample_out;
  logic             res_valid;
  logic [WIDTH-1:0] res_peak;
  logic [IW-1:0]    res_idx;

  modport master (
    output start, in_valid, sample_out,
    input  res_valid, res_peak, res_idx
  );

  modport slave (
    input  start, in_valid, sample_out,
    output res_valid, res_peak, res_idx
  );
endinterface

// File: rtl/peak_frame_sequencer.sv
// rtl/peak_frame_sequencer.sv - streams a stored frame into peak_abs and captures its result
module peak_frame_sequencer #(
  parameter int WIDTH     = 16,
  parameter int N_SAMPLES = 16,
  parameter int TIMEOUT   = 1000,
  parameter int IW        = $clog2(N_SAMPLES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [IW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   go,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH-1:0]       peak,
  output logic [IW-1:0]          peak_idx,
  output logic                   timeout_err,
  peak_frame_sequencer_if.master det
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_STREAM, S_WAIT} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] frame [N_SAMPLES];
  logic [IW-1:0]    k;
  logic [CW-1:0]    cnt;
  logic             start_q;
  logic             in_valid_q;
  logic [WIDTH-1:0] sample_q;
  logic             wr_hit;
  logic             last_beat;
  logic             timed_out;

  assign wr_hit    = wr_en && (state == S_IDLE) && ({1'b0, wr_addr} < (IW+1)'(N_SAMPLES));
  assign last_beat = (k == IW'(N_SAMPLES - 1));
  assign timed_out = (cnt == CW'(TIMEOUT - 1));

  assign det.start      = start_q;
  assign det.in_valid   = in_valid_q;
  assign det.sample_out = sample_q;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (go) state_next = S_START;
      S_START:  state_next = S_STREAM;
      S_STREAM: if (last_beat) state_next = S_WAIT;
      S_WAIT:   if (det.res_valid || timed_out) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one lines up with its state's cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      k           <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      start_q     <= 1'b0;
      in_valid_q  <= 1'b0;
      sample_q    <= '0;
      done        <= 1'b0;
      peak        <= '0;
      peak_idx    <= '0;
      timeout_err <= 1'b0;
      for (int i = 0; i < N_SAMPLES; i++) frame[i] <= '0;
    end else begin
      state   <= state_next;
      busy    <= (state_next != S_IDLE);
      start_q <= (state_next == S_START);
      done    <= 1'b0;
      if (wr_hit) frame[wr_addr] <= wr_data;
      case (state)
        S_IDLE: begin
          if (go) begin
            timeout_err <= 1'b0;
            cnt         <= '0;
            k           <= '0;
          end
        end
        S_START: begin
          in_valid_q <= 1'b1;
          sample_q   <= frame[0];
          k          <= '0;
        end
        S_STREAM: begin
          if (last_beat) begin
            in_valid_q <= 1'b0;
            sample_q   <= '0;
          end else begin
            sample_q <= frame[k + IW'(1)];
            k        <= k + IW'(1);
          end
        end
        S_WAIT: begin
          cnt <= cnt + CW'(1);
          // A result arriving on the final allowed cycle still wins over the timeout.
          if (det.res_valid) begin
            peak     <= det.res_peak;
            peak_idx <= det.res_idx;
            done     <= 1'b1;
          end else if (timed_out) begin
            peak        <= '0;
            peak_idx    <= '0;
            timeout_err <= 1'b1;
            done        <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_peak_frame_sequencer.sv
// tb/tb_peak_frame_sequencer.sv - scoreboard bench for peak_frame_sequencer
module tb_peak_frame_sequencer;

  localparam int N  = 16;
  localparam int TO = 1000;

  typedef struct { logic [15:0] s; int c; } beat_t;
  typedef struct { logic [15:0] p; logic [3:0] x; logic t; int c; } res_t;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        go;
  logic        busy;
  logic        done;
  logic [15:0] peak;
  logic [3:0]  peak_idx;
  logic        timeout_err;

  peak_frame_sequencer_if #(.WIDTH(16), .IW(4)) det_if ();

  peak_frame_sequencer #(.WIDTH(16), .N_SAMPLES(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .go(go), .busy(busy), .done(done), .peak(peak), .peak_idx(peak_idx),
    .timeout_err(timeout_err), .det(det_if)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  int    exp_start [$];
  beat_t exp_beats [$];
  res_t  exp_res   [$];
  logic [15:0] model [N];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    beat_t b;
    res_t  r;
    int    c;
    if (det_if.start) begin
      if (exp_start.size() == 0) check("unexpected_start", 1, 0);
      else begin
        c = exp_start.pop_front();
        check("start_cycle", cyc, c);
      end
    end
    if (det_if.in_valid) begin
      if (exp_beats.size() == 0) check("unexpected_beat", 1, 0);
      else begin
        b = exp_beats.pop_front();
        check("beat_sample", det_if.sample_out, b.s);
        check("beat_cycle", cyc, b.c);
      end
    end
    if (done) begin
      if (exp_res.size() == 0) check("unexpected_done", 1, 0);
      else begin
        r = exp_res.pop_front();
        check("done_peak", peak, r.p);
        check("done_idx", peak_idx, r.x);
        check("done_terr", timeout_err, r.t);
        check("done_cycle", cyc, r.c);
        check("done_sample_zero", {det_if.in_valid, det_if.sample_out}, 0);
      end
    end
  end

  task automatic write(input logic [3:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    model[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Called right after a negedge; returns at the negedge of the done cycle.
  task automatic launch(input int rdel, input logic [15:0] rp, input logic [3:0] ri,
                        input bit do_wr, input logic [3:0] wa, input logic [15:0] wd,
                        input bit intrude);
    int go_edge, wait_c, res_c, done_c;
    go = 1'b1; wr_en = do_wr; wr_addr = wa; wr_data = wd;
    det_if.res_valid = 1'b0;
    if (do_wr) model[wa] = wd;
    go_edge = cyc + 1;
    wait_c  = go_edge + N + 1;
    res_c   = -1;
    exp_start.push_back(go_edge);
    for (int i = 0; i < N; i++) exp_beats.push_back('{s: model[i], c: go_edge + 1 + i});
    if (rdel >= 0) begin
      res_c  = wait_c + rdel;
      done_c = res_c + 1;
      exp_res.push_back('{p: rp, x: ri, t: 1'b0, c: done_c});
    end else begin
      done_c = wait_c + TO;
      exp_res.push_back('{p: 16'd0, x: 4'd0, t: 1'b1, c: done_c});
    end
    @(negedge clk);
    go = 1'b0; wr_en = 1'b0;
    check("busy_at_start", busy, 1);
    check("terr_cleared", timeout_err, 0);
    while (cyc < done_c) begin
      det_if.res_valid = (cyc == res_c);
      det_if.res_peak  = rp;
      det_if.res_idx   = ri;
      go      = intrude && (cyc == go_edge + 5);
      wr_en   = go;
      wr_addr = 4'd3;
      wr_data = 16'd7777;
      @(negedge clk);
    end
    det_if.res_valid = 1'b0;
    go = 1'b0; wr_en = 1'b0;
    check("busy_at_done", busy, 0);
  endtask

  initial begin
    int vals [N] = '{12, -45, 78, -300, 150, -200, 50, 0, -1024, 77, 25, -999, 500, -250, 1023, -700};
    int go_edge;

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; go = 1'b0;
    det_if.res_valid = 1'b0; det_if.res_peak = '0; det_if.res_idx = '0;
    for (int i = 0; i < N; i++) model[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {busy, det_if.start, det_if.in_valid, det_if.sample_out, done}, 0);
    check("rst_result", {peak, peak_idx, timeout_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy, 0);

    // Normal frame
    for (int i = 0; i < N; i++) write(4'(i), 16'(vals[i]));
    @(negedge clk);
    launch(3, 16'd1024, 4'd8, 0, 0, 0, 0);
    repeat (2) @(negedge clk);

    // Timeout
    launch(-1, 16'd0, 4'd0, 0, 0, 0, 0);
    @(negedge clk);
    check("terr_held", timeout_err, 1);
    check("peak_after_timeout", peak, 0);

    // Writes and go during STREAM are ignored; the next go clears timeout_err
    launch(1, 16'd1023, 4'd14, 0, 0, 0, 1);
    repeat (2) @(negedge clk);

    // Same-cycle write+go; buf[3] must still be -300
    launch(2, 16'd1024, 4'd8, 1, 4'd0, -16'sd5, 0);
    repeat (2) @(negedge clk);

    // Reset after 5 beats
    go = 1'b1;
    go_edge = cyc + 1;
    exp_start.push_back(go_edge);
    for (int i = 0; i < 5; i++) exp_beats.push_back('{s: model[i], c: go_edge + 1 + i});
    @(negedge clk);
    go = 1'b0;
    while (cyc < go_edge + 5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_stream", {det_if.in_valid, busy, det_if.start, det_if.sample_out}, 0);
    check("midrst_result", {done, peak, peak_idx, timeout_err}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) model[i] = '0;
    @(negedge clk);
    launch(2, 16'd0, 4'd0, 0, 0, 0, 0);

    // Back-to-back: go in the done cycle
    launch(3, 16'd77, 4'd5, 0, 0, 0, 0);
    launch(0, 16'd1023, 4'd14, 0, 0, 0, 0);
    @(negedge clk);
    det_if.res_valid = 1'b1; det_if.res_peak = 16'd9999; det_if.res_idx = 4'd3;
    @(negedge clk);
    det_if.res_valid = 1'b0;
    @(negedge clk);
    check("stray_res_peak", peak, 1023);
    check("stray_res_idx", peak_idx, 14);

    repeat (5) @(negedge clk);
    check("pending_starts", exp_start.size(), 0);
    check("pending_beats", exp_beats.size(), 0);
    check("pending_results", exp_res.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
